modulation_az_sequencer: RTL and testbench

//  Auto-zero measurement sequencer in front of the ADC measure core. Drives the precharge

---
 rtl/modulation_az_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_modulation_az_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulation_az_sequencer.sv
// Auto-zero measurement sequencer: alternates HI (signal) and LO (zero)
// conversions, drives the precharge switch, AZ mux and ADC trigger, and
// latches a sticky fault when the ADC never reports completion.
module modulation_az_sequencer #(
    parameter int unsigned CLK_FREQ     = 20000000,
    parameter int unsigned PC_DEFAULT_N = CLK_FREQ / 2000,
    parameter int unsigned TIMEOUT_N    = CLK_FREQ / 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run,
    input  logic [23:0] i_clk_count_precharge_n,
    input  logic [3:0]  i_azmux_lo_val,
    input  logic [3:0]  i_azmux_hi_val,
    input  logic        i_adc_measure_valid,
    output logic        o_adc_measure_trig,
    output logic        o_sw_pc_ctl,
    output logic [3:0]  o_azmux,
    output logic        o_az_phase,
    output logic [7:0]  o_sample_count,
    output logic        o_fault,
    output logic        o_led0,
    output logic [1:0]  o_monitor
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PC_BOOT,
        S_AZ_HI,
        S_TRIG_HI,
        S_WAIT_HI,
        S_PC_BOOT2,
        S_AZ_LO,
        S_TRIG_LO,
        S_WAIT_LO
    } state_t;

    localparam logic [23:0] PC_DEFAULT_M1 = 24'(PC_DEFAULT_N - 1);
    localparam logic [23:0] TIMEOUT_M1    = 24'(TIMEOUT_N - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_cnt;
    logic [3:0]  r_azmux;
    logic        r_hi_sel;
    logic        r_az_phase;
    logic [7:0]  r_sample_count;
    logic        r_fault;
    logic        r_led0;
    logic        r_blank;

    logic        w_cnt_zero;
    logic [23:0] w_settle_m1;
    logic        w_ld_settle;
    logic        w_ld_timeout;
    logic        w_dec;
    logic        w_pair_done;
    logic        w_timeout;
    logic        w_hi_sel_nxt;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_settle_m1 = (i_clk_count_precharge_n == '0) ? PC_DEFAULT_M1
                                                         : i_clk_count_precharge_n - 24'd1;

    // Next-state decode; the shared counter is loaded with S-1 on settle entry
    // and TIMEOUT_N-1 on trig entry, so a state lasts exactly S (or TIMEOUT_N) clocks.
    always_comb begin
        w_state_nxt  = r_state;
        w_ld_settle  = 1'b0;
        w_ld_timeout = 1'b0;
        w_dec        = 1'b0;
        w_pair_done  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run && !r_fault) begin
                    w_state_nxt = S_PC_BOOT;
                    w_ld_settle = 1'b1;
                end
            end
            S_PC_BOOT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_AZ_HI;
                    w_ld_settle = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_AZ_HI: begin
                if (w_cnt_zero) begin
                    w_state_nxt  = S_TRIG_HI;
                    w_ld_timeout = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_TRIG_HI: begin
                w_state_nxt = S_WAIT_HI;
                w_dec       = 1'b1;
            end
            S_WAIT_HI: begin
                if (!r_blank && i_adc_measure_valid) begin
                    w_state_nxt = S_PC_BOOT2;
                    w_ld_settle = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_PC_BOOT2: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_AZ_LO;
                    w_ld_settle = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_AZ_LO: begin
                if (w_cnt_zero) begin
                    w_state_nxt  = S_TRIG_LO;
                    w_ld_timeout = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_TRIG_LO: begin
                w_state_nxt = S_WAIT_LO;
                w_dec       = 1'b1;
            end
            S_WAIT_LO: begin
                if (!r_blank && i_adc_measure_valid) begin
                    w_pair_done = 1'b1;
                    if (i_run) begin
                        w_state_nxt = S_AZ_HI;
                        w_ld_settle = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The mux follows the HI input from AZ_HI until AZ_LO selects the zero input.
    assign w_hi_sel_nxt = (w_state_nxt == S_AZ_HI) || (w_state_nxt == S_TRIG_HI) ||
                          (w_state_nxt == S_WAIT_HI) || (w_state_nxt == S_PC_BOOT2);

    // State register and shared settle/timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_blank <= (r_state == S_TRIG_HI) || (r_state == S_TRIG_LO);
            if (w_ld_settle) begin
                r_cnt <= w_settle_m1;
            end else if (w_ld_timeout) begin
                r_cnt <= TIMEOUT_M1;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 24'd1;
            end
        end
    end

    // Registered mux select, phase tag, pair counter, LED and sticky fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_azmux        <= '0;
            r_hi_sel       <= 1'b0;
            r_az_phase     <= 1'b0;
            r_sample_count <= '0;
            r_fault        <= 1'b0;
            r_led0         <= 1'b0;
        end else begin
            r_hi_sel <= w_hi_sel_nxt;
            r_azmux  <= w_hi_sel_nxt ? i_azmux_hi_val : i_azmux_lo_val;
            if (w_state_nxt == S_TRIG_HI) begin
                r_az_phase <= 1'b1;
            end else if (w_state_nxt == S_TRIG_LO) begin
                r_az_phase <= 1'b0;
            end
            if (w_pair_done) begin
                r_sample_count <= r_sample_count + 8'd1;
                r_led0         <= ~r_led0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_adc_measure_trig = (r_state == S_TRIG_HI) || (r_state == S_TRIG_LO);
    assign o_sw_pc_ctl        = (r_state == S_TRIG_HI) || (r_state == S_WAIT_HI);
    assign o_azmux            = r_azmux;
    assign o_az_phase         = r_az_phase;
    assign o_sample_count     = r_sample_count;
    assign o_fault            = r_fault;
    assign o_led0             = r_led0;
    assign o_monitor          = {o_adc_measure_trig, r_hi_sel};

endmodule

// File: tb/tb_modulation_az_sequencer.sv
// Directed bench for the auto-zero sequencer; a small ADC model answers
// trigs after a programmable delay, always, or never.
module tb_modulation_az_sequencer;

    localparam int unsigned TIMEOUT = 500;
    localparam logic [3:0]  LO = 4'h3;
    localparam logic [3:0]  HI = 4'hC;

    // Observation word: {trig, sw_pc_ctl, az_phase, monitor[1:0], azmux}
    localparam logic [8:0] OB_IDLE   = 9'b0_0_0_00_0011;
    localparam logic [8:0] OB_HI0    = 9'b0_0_0_01_1100;
    localparam logic [8:0] OB_TRIGHI = 9'b1_1_1_11_1100;
    localparam logic [8:0] OB_WAITHI = 9'b0_1_1_01_1100;
    localparam logic [8:0] OB_PCB2   = 9'b0_0_1_01_1100;
    localparam logic [8:0] OB_AZLO   = 9'b0_0_1_00_0011;
    localparam logic [8:0] OB_TRIGLO = 9'b1_0_0_10_0011;
    localparam logic [8:0] OB_WAITLO = 9'b0_0_0_00_0011;
    localparam logic [8:0] OB_FAULT  = 9'b0_0_1_00_0011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [23:0] n = 24'd4;
    logic        valid;
    logic        trig, sw, phase, fault, led0;
    logic [3:0]  azmux;
    logic [7:0]  cnt;
    logic [1:0]  mon;
    logic [8:0]  obs;

    int n_vec = 0;
    int n_err = 0;
    int adc_mode = 0;   // 0 = answer after adc_delay, 1 = always valid, 2 = never valid
    int adc_delay = 10;

    modulation_az_sequencer #(.TIMEOUT_N(TIMEOUT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .i_run                   (run),
        .i_clk_count_precharge_n (n),
        .i_azmux_lo_val          (LO),
        .i_azmux_hi_val          (HI),
        .i_adc_measure_valid     (valid),
        .o_adc_measure_trig      (trig),
        .o_sw_pc_ctl             (sw),
        .o_azmux                 (azmux),
        .o_az_phase              (phase),
        .o_sample_count          (cnt),
        .o_fault                 (fault),
        .o_led0                  (led0),
        .o_monitor               (mon)
    );

    assign obs = {trig, sw, phase, mon, azmux};

    always #5 clk = ~clk;

    // ADC model
    initial begin
        valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (adc_mode == 2) begin
                valid = 1'b0;
            end else if (adc_mode == 1) begin
                valid = 1'b1;
            end else if (trig) begin
                valid = 1'b0;
                repeat (adc_delay) @(posedge clk);
                #1;
                valid = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({obs[8:4], cnt, fault, led0} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_vals got=%b,%0d,%b,%b want=0", obs[8:4], cnt, fault, led0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (obs !== OB_IDLE) begin
            n_err++;
            $display("FAIL reset_first_clk obs=%b want=%b", obs, OB_IDLE);
        end
    endtask

    task automatic test_basic_pair();
        logic [8:0] exp;
        bit chk;
        int ntrig;
        do_reset();
        n = 24'd4; adc_mode = 0; adc_delay = 10; ntrig = 0;
        run = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            if (trig) ntrig++;
            chk = 1'b1;
            case (c)
                4:       exp = OB_IDLE;
                5, 8:    exp = OB_HI0;
                9:       exp = OB_TRIGHI;
                10, 19:  exp = OB_WAITHI;
                20, 23:  exp = OB_PCB2;
                24, 27:  exp = OB_AZLO;
                28:      exp = OB_TRIGLO;
                29, 38:  exp = OB_WAITLO;
                39:      exp = OB_HI0;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL basic_seq c=%0d obs=%b want=%b", c, obs, exp);
                end
            end
            if (c == 38 || c == 39) begin
                n_vec++;
                if ({cnt, led0} !== ((c == 39) ? 9'b0000_0001_1 : 9'd0)) begin
                    n_err++;
                    $display("FAIL basic_count c=%0d cnt=%0d led=%b", c, cnt, led0);
                end
            end
        end
        n_vec++;
        if (ntrig !== 2) begin
            n_err++;
            $display("FAIL basic_trigs got=%0d want=2", ntrig);
        end
    endtask

    task automatic test_default_settle();
        int hit;
        do_reset();
        n = 24'd0; adc_mode = 0; hit = 0;
        run = 1'b1;
        for (int c = 1; c <= 12000; c++) begin
            @(negedge clk);
            if (c == 100) n = 24'd4;
            if (azmux === HI) begin
                hit = c;
                break;
            end
        end
        n_vec++;
        if (hit !== 10001) begin
            n_err++;
            $display("FAIL default_settle hi_at=%0d want=10001", hit);
        end
    endtask

    task automatic test_valid_stuck();
        logic [8:0] exp;
        bit chk;
        int ntrig;
        do_reset();
        n = 24'd2; adc_mode = 1; ntrig = 0;
        run = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            if (trig) ntrig++;
            chk = 1'b1;
            case (c)
                5:       exp = OB_TRIGHI;
                6, 7:    exp = OB_WAITHI;
                8:       exp = OB_PCB2;
                10:      exp = OB_AZLO;
                12:      exp = OB_TRIGLO;
                13:      exp = OB_WAITLO;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL stuck_seq c=%0d obs=%b want=%b", c, obs, exp);
                end
            end
            if (c == 14 || c == 15 || c == 26 || c == 27) begin
                n_vec++;
                if (cnt !== ((c == 14) ? 8'd0 : (c == 27) ? 8'd2 : 8'd1)) begin
                    n_err++;
                    $display("FAIL stuck_count c=%0d cnt=%0d", c, cnt);
                end
            end
        end
        n_vec++;
        if (ntrig !== 4) begin
            n_err++;
            $display("FAIL stuck_trigs got=%0d want=4", ntrig);
        end
    endtask

    task automatic test_stop_mid_pair();
        int ntrig;
        do_reset();
        n = 24'd4; adc_mode = 0; adc_delay = 10; ntrig = 0;
        run = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (trig) ntrig++;
            if (c == 15) run = 1'b0;
            if (c == 28) begin
                n_vec++;
                if (obs !== OB_TRIGLO) begin
                    n_err++;
                    $display("FAIL stop_lo_trig obs=%b want=%b", obs, OB_TRIGLO);
                end
            end
            if (c == 39 || c == 45 || c == 60) begin
                n_vec++;
                if ({obs, cnt, led0} !== {OB_IDLE, 8'd1, 1'b1}) begin
                    n_err++;
                    $display("FAIL stop_idle c=%0d obs=%b cnt=%0d led=%b want=%b,1,1",
                             c, obs, cnt, led0, OB_IDLE);
                end
            end
        end
        n_vec++;
        if (ntrig !== 2) begin
            n_err++;
            $display("FAIL stop_trigs got=%0d want=2", ntrig);
        end
    endtask

    task automatic test_timeout();
        int ntrig;
        do_reset();
        n = 24'd2; adc_mode = 2; ntrig = 0;
        run = 1'b1;
        for (int c = 1; c <= 560; c++) begin
            @(negedge clk);
            if (trig) ntrig++;
            if (c == 520) run = 1'b0;
            if (c == 530) run = 1'b1;
            if (c == 504) begin
                n_vec++;
                if ({obs, fault} !== {OB_WAITHI, 1'b0}) begin
                    n_err++;
                    $display("FAIL timeout_early obs=%b fault=%b want=%b,0", obs, fault, OB_WAITHI);
                end
            end
            if (c == 505 || c == 560) begin
                n_vec++;
                if ({obs, fault} !== {OB_FAULT, 1'b1}) begin
                    n_err++;
                    $display("FAIL timeout_fault c=%0d obs=%b fault=%b want=%b,1",
                             c, obs, fault, OB_FAULT);
                end
            end
        end
        n_vec++;
        if (ntrig !== 1) begin
            n_err++;
            $display("FAIL timeout_trigs got=%0d want=1", ntrig);
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        int incs;
        int ntrig;
        logic [7:0] prev;
        do_reset();
        n = 24'd4; adc_mode = 0; adc_delay = 10; ntrig = 0;
        run = 1'b1;
        for (int c = 1; c <= 59; c++) begin
            @(negedge clk);
            if (c == 39 || c == 59) begin
                n_vec++;
                if ({cnt, led0} !== 9'b0000_0001_1) begin
                    n_err++;
                    $display("FAIL mid_pre_count c=%0d cnt=%0d led=%b", c, cnt, led0);
                end
            end
        end
        n_vec++;
        if (obs !== OB_AZLO) begin
            n_err++;
            $display("FAIL mid_in_azlo obs=%b want=%b", obs, OB_AZLO);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({obs[8:4], cnt, fault, led0} !== 15'd0) begin
            n_err++;
            $display("FAIL mid_reset_vals got=%b,%0d,%b,%b want=0", obs[8:4], cnt, fault, led0);
        end
        repeat (3) begin
            @(negedge clk);
            if (trig) ntrig++;
        end
        reset = 1'b0;
        run = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({obs, ntrig[3:0]} !== {OB_IDLE, 4'd0}) begin
            n_err++;
            $display("FAIL mid_after_reset obs=%b trigs=%0d want=%b,0", obs, ntrig, OB_IDLE);
        end
        // 256 pairs back to back
        n = 24'd1; adc_mode = 1; incs = 0; prev = cnt;
        run = 1'b1;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            if (cnt !== prev) begin
                incs++;
                prev = cnt;
                if (incs == 255) begin
                    n_vec++;
                    if (cnt !== 8'd255) begin
                        n_err++;
                        $display("FAIL wrap_255 cnt=%0d want=255", cnt);
                    end
                end
                if (incs == 256) begin
                    n_vec++;
                    if ({cnt, led0} !== 9'd0) begin
                        n_err++;
                        $display("FAIL wrap_0 cnt=%0d led=%b want=0,0", cnt, led0);
                    end
                    break;
                end
            end
        end
        n_vec++;
        if (incs !== 256) begin
            n_err++;
            $display("FAIL wrap_budget pairs=%0d want=256", incs);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_default_settle();
        test_valid_stuck();
        test_stop_mid_pair();
        test_timeout();
        test_reset_mid_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
